cic_integrator_bank: RTL and testbench

CIC_INTEGRATOR_BANK -- requirements
Module: cic_integrator_bank

---
 rtl/cic_pkg.sv | 23 ++
 rtl/cic_integ_stage.sv | 72 +++++++
 rtl/cic_integrator_bank.sv | 83 ++++++++
 tb/tb_cic_integrator_bank.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared helpers for the CIC integrator bank: port-width derivation and
// the filter-order clamp used to decide which stages integrate.
package cic_pkg;

  // Channel index width; a single channel still needs one index bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Width of the order field, wide enough to hold the value NUM_STAGES.
  function automatic int order_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  // Orders below 1 run as 1, orders above the built stage count run as
  // the full cascade.
  function automatic int clamp_order(input int order, input int num_stages);
    if (order < 1) return 1;
    if (order > num_stages) return num_stages;
    return order;
  endfunction

endpackage

// File: rtl/cic_integ_stage.sv
// One integrator stage: a per-channel accumulator bank plus the pipeline
// register carrying valid, channel and data to the next stage.
module cic_integ_stage #(
  parameter int ACC_WIDTH = 64,
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 adv_i,
  input  logic                 bypass_i,
  input  logic                 valid_i,
  input  logic [CH_W-1:0]      ch_i,
  input  logic [ACC_WIDTH-1:0] data_i,
  output logic                 valid_o,
  output logic [CH_W-1:0]      ch_o,
  output logic [ACC_WIDTH-1:0] data_o
);

  logic [ACC_WIDTH-1:0] acc_q [NUM_CH];
  logic [ACC_WIDTH-1:0] acc_sel;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] data_d;
  logic                 take;

  logic                 valid_q;
  logic [CH_W-1:0]      ch_q;
  logic [ACC_WIDTH-1:0] data_q;

  // Select the accumulator of the incoming channel and form the stage result.
  always_comb begin
    acc_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_i == CH_W'(c)) acc_sel = acc_q[c];
    end
    sum    = acc_sel + data_i;
    data_d = bypass_i ? data_i : sum;
    take   = adv_i && valid_i;
  end

  // Accumulators only move when a valid sample passes through an active stage.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else if (take && !bypass_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_i == CH_W'(c)) acc_q[c] <= sum;
      end
    end
  end

  // Pipeline register; frozen as a whole while the bank is stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      data_q  <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        ch_q   <= ch_i;
        data_q <= data_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign ch_o    = ch_q;
  assign data_o  = data_q;

endmodule

// File: rtl/cic_integrator_bank.sv
// Multi-channel cascaded integrator bank. Samples of any channel enter one
// per cycle and leave NUM_STAGES cycles later; stages at or beyond the
// active order pass data through so latency never depends on the order.
module cic_integrator_bank
  import cic_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int ACC_WIDTH  = 64,
  parameter int NUM_CH     = 4,
  parameter int NUM_STAGES = 5
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clr_i,
  input  logic [order_width(NUM_STAGES)-1:0]   cfg_order_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic [ch_width(NUM_CH)-1:0]          ch_i,
  input  logic [IN_WIDTH-1:0]                  data_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [ch_width(NUM_CH)-1:0]          ch_o,
  output logic [ACC_WIDTH-1:0]                 data_o
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic                 adv;
  logic                 in_range;
  logic [NUM_STAGES-1:0] bypass;
  int                   order_eff;

  logic                 v_chain  [NUM_STAGES+1];
  logic [CH_W-1:0]      ch_chain [NUM_STAGES+1];
  logic [ACC_WIDTH-1:0] d_chain  [NUM_STAGES+1];

  // Global advance: the pipeline only moves when the output slot can drain.
  always_comb begin
    adv      = !valid_o || ready_i;
    ready_o  = adv && !clr_i && !rst_i;
    in_range = ({1'b0, ch_i} < NUM_CH_L);
  end

  // Stage enables from the clamped order; higher stages become pass-through.
  always_comb begin
    bypass    = '0;
    order_eff = clamp_order(int'(cfg_order_i), NUM_STAGES);
    for (int k = 0; k < NUM_STAGES; k++) begin
      bypass[k] = (k >= order_eff);
    end
  end

  // Out-of-range channels are handshaked but never enter the pipeline.
  assign v_chain[0]  = valid_i && ready_o && in_range;
  assign ch_chain[0] = ch_i;
  assign d_chain[0]  = ACC_WIDTH'($signed(data_i));

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    cic_integ_stage #(
      .ACC_WIDTH (ACC_WIDTH),
      .NUM_CH    (NUM_CH),
      .CH_W      (CH_W)
    ) u_stage (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (clr_i),
      .adv_i    (adv),
      .bypass_i (bypass[k]),
      .valid_i  (v_chain[k]),
      .ch_i     (ch_chain[k]),
      .data_i   (d_chain[k]),
      .valid_o  (v_chain[k+1]),
      .ch_o     (ch_chain[k+1]),
      .data_o   (d_chain[k+1])
    );
  end

  assign valid_o = v_chain[NUM_STAGES];
  assign ch_o    = ch_chain[NUM_STAGES];
  assign data_o  = d_chain[NUM_STAGES];

endmodule

// File: tb/tb_cic_integrator_bank.sv
// Bench for the CIC integrator bank: directed scenarios on a small 8-bit
// instance and randomized traffic on a wider instance against a serial model.
module tb_cic_integrator_bank;

  localparam int A_IN = 8, A_ACC = 8, A_CH = 3, A_ST = 3;
  localparam int B_IN = 8, B_ACC = 20, B_CH = 3, B_ST = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // instance A
  logic       rst_a, clr_a, valid_i_a, ready_o_a, valid_o_a, ready_i_a;
  logic [1:0] order_a, ch_i_a, ch_o_a;
  logic [7:0] data_i_a, data_o_a;

  // instance B
  logic        rst_b, clr_b, valid_i_b, ready_o_b, valid_o_b, ready_i_b;
  logic [2:0]  order_b;
  logic [1:0]  ch_i_b, ch_o_b;
  logic [7:0]  data_i_b;
  logic [19:0] data_o_b;

  cic_integrator_bank #(.IN_WIDTH(A_IN), .ACC_WIDTH(A_ACC), .NUM_CH(A_CH), .NUM_STAGES(A_ST)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .clr_i(clr_a), .cfg_order_i(order_a),
    .valid_i(valid_i_a), .ready_o(ready_o_a), .ch_i(ch_i_a), .data_i(data_i_a),
    .valid_o(valid_o_a), .ready_i(ready_i_a), .ch_o(ch_o_a), .data_o(data_o_a));

  cic_integrator_bank #(.IN_WIDTH(B_IN), .ACC_WIDTH(B_ACC), .NUM_CH(B_CH), .NUM_STAGES(B_ST)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .clr_i(clr_b), .cfg_order_i(order_b),
    .valid_i(valid_i_b), .ready_o(ready_o_b), .ch_i(ch_i_b), .data_i(data_i_b),
    .valid_o(valid_o_b), .ready_i(ready_i_b), .ch_o(ch_o_b), .data_o(data_o_b));

  logic [1:0] got_ch [$];
  logic [7:0] got_d  [$];
  int         got_cyc[$];

  // ---------------- instance A helpers ----------------
  task automatic tick_a();
    @(negedge clk);
    if (valid_o_a && ready_i_a) begin
      got_ch.push_back(ch_o_a);
      got_d.push_back(data_o_a);
      got_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_a(input logic v, input logic [1:0] ch, input logic [7:0] d);
    valid_i_a = v; ch_i_a = ch; data_i_a = d;
    tick_a();
  endtask

  task automatic idle_a(input int n);
    repeat (n) drive_a(1'b0, 2'd0, 8'd0);
  endtask

  task automatic flush_a();
    got_ch.delete(); got_d.delete(); got_cyc.delete();
  endtask

  task automatic set_order_a(input logic [1:0] o);
    order_a = o; clr_a = 1'b1; valid_i_a = 1'b0;
    tick_a();
    clr_a = 1'b0;
    flush_a();
  endtask

  // ---------------- instance B model ----------------
  longint      macc [B_ST][B_CH];
  logic [19:0] exp_d [$];
  logic [1:0]  exp_ch[$];
  logic        prev_stall;
  logic [19:0] prev_d;
  logic [1:0]  prev_ch;

  task automatic model_clear_b();
    for (int k = 0; k < B_ST; k++)
      for (int c = 0; c < B_CH; c++) macc[k][c] = 0;
  endtask

  task automatic model_push_b(input logic [1:0] ch, input logic [7:0] d);
    longint mask = (longint'(1) << B_ACC) - 1;
    int     eff;
    longint x;
    eff = (order_b == 0) ? 1 : ((int'(order_b) > B_ST) ? B_ST : int'(order_b));
    x = longint'($signed(d));
    for (int k = 0; k < eff; k++) begin
      macc[k][ch] = (macc[k][ch] + x) & mask;
      x = macc[k][ch];
    end
    exp_d.push_back(20'(x & mask));
    exp_ch.push_back(ch);
  endtask

  task automatic cycle_b();
    @(negedge clk);
    n_cmp++;
    if (ready_o_b !== (!valid_o_b || ready_i_b)) begin
      n_bad++;
      $display("FAIL rand_ready_o: got %0b expected %0b", ready_o_b, (!valid_o_b || ready_i_b));
    end
    if (prev_stall) begin
      n_cmp++;
      if (valid_o_b !== 1'b1 || data_o_b !== prev_d || ch_o_b !== prev_ch) begin
        n_bad++;
        $display("FAIL rand_stall_hold: got v=%0b d=%0h ch=%0d expected v=1 d=%0h ch=%0d",
                 valid_o_b, data_o_b, ch_o_b, prev_d, prev_ch);
      end
    end
    if (valid_o_b && ready_i_b) begin
      n_cmp++;
      if (exp_d.size() == 0) begin
        n_bad++;
        $display("FAIL rand_spurious: got d=%0h ch=%0d expected no output", data_o_b, ch_o_b);
      end else begin
        logic [19:0] ed;
        logic [1:0]  ec;
        ed = exp_d.pop_front();
        ec = exp_ch.pop_front();
        if (data_o_b !== ed || ch_o_b !== ec) begin
          n_bad++;
          $display("FAIL rand_out: got d=%0h ch=%0d expected d=%0h ch=%0d", data_o_b, ch_o_b, ed, ec);
        end
      end
    end
    if (valid_i_b && ready_o_b && ch_i_b < 2'(B_CH)) model_push_b(ch_i_b, data_i_b);
    prev_stall = valid_o_b && !ready_i_b;
    prev_d  = data_o_b;
    prev_ch = ch_o_b;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_a = 1'b1; clr_a = 1'b0; order_a = 2'd3; valid_i_a = 1'b0; ch_i_a = '0; data_i_a = '0; ready_i_a = 1'b1;
    rst_b = 1'b1; clr_b = 1'b0; order_b = 3'd5; valid_i_b = 1'b0; ch_i_b = '0; data_i_b = '0; ready_i_b = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (ready_o_a !== 1'b0 || valid_o_a !== 1'b0 || data_o_a !== 8'd0 || ch_o_a !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_a: got rdy=%0b v=%0b d=%0d ch=%0d expected 0 0 0 0", ready_o_a, valid_o_a, data_o_a, ch_o_a);
    end
    n_cmp++;
    if (ready_o_b !== 1'b0 || valid_o_b !== 1'b0 || data_o_b !== 20'd0 || ch_o_b !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_b: got rdy=%0b v=%0b d=%0d ch=%0d expected 0 0 0 0", ready_o_b, valid_o_b, data_o_b, ch_o_b);
    end
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    flush_a();
  endtask

  task automatic test_impulse();
    int c0;
    logic [7:0] e [4] = '{8'd1, 8'd3, 8'd6, 8'd10};
    set_order_a(2'd3);
    c0 = cyc;
    drive_a(1'b1, 2'd0, 8'd1);
    repeat (3) drive_a(1'b1, 2'd0, 8'd0);
    idle_a(6);
    n_cmp++;
    if (got_d.size() != 4) begin
      n_bad++;
      $display("FAIL impulse_count: got %0d expected 4", got_d.size());
    end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== e[i] || got_ch[i] !== 2'd0) begin
        n_bad++;
        $display("FAIL impulse_out[%0d]: got d=%0d ch=%0d expected d=%0d ch=0", i, got_d[i], got_ch[i], e[i]);
      end
    end
    if (got_cyc.size() > 0) begin
      n_cmp++;
      if (got_cyc[0] - c0 != A_ST) begin
        n_bad++;
        $display("FAIL impulse_latency: got %0d expected %0d", got_cyc[0] - c0, A_ST);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e1 [3] = '{8'd100, 8'd200, 8'd44};
    logic [7:0] e2 [2] = '{8'd255, 8'd254};
    set_order_a(2'd1);
    repeat (3) drive_a(1'b1, 2'd0, 8'd100);
    idle_a(4);
    n_cmp++;
    if (got_d.size() != 3) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d expected 3", got_d.size());
    end
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== e1[i]) begin
        n_bad++;
        $display("FAIL wrap_out[%0d]: got %0d expected %0d", i, got_d[i], e1[i]);
      end
    end
    set_order_a(2'd1);
    repeat (2) drive_a(1'b1, 2'd0, 8'hFF);
    idle_a(4);
    n_cmp++;
    if (got_d.size() != 2) begin
      n_bad++;
      $display("FAIL wrap_neg_count: got %0d expected 2", got_d.size());
    end
    for (int i = 0; i < 2 && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== e2[i]) begin
        n_bad++;
        $display("FAIL wrap_neg_out[%0d]: got %0d expected %0d", i, got_d[i], e2[i]);
      end
    end
  endtask

  task automatic test_interleave();
    logic [7:0] ed [6] = '{8'd1, 8'd2, 8'd3, 8'd6, 8'd6, 8'd12};
    logic [1:0] ec [6] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    set_order_a(2'd2);
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 2'd0, 8'd1);
      drive_a(1'b1, 2'd1, 8'd2);
    end
    idle_a(5);
    n_cmp++;
    if (got_d.size() != 6) begin
      n_bad++;
      $display("FAIL interleave_count: got %0d expected 6", got_d.size());
    end
    for (int i = 0; i < 6 && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== ed[i] || got_ch[i] !== ec[i]) begin
        n_bad++;
        $display("FAIL interleave_out[%0d]: got d=%0d ch=%0d expected d=%0d ch=%0d", i, got_d[i], got_ch[i], ed[i], ec[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int s1 = 0, s2 = 0, s3 = 0;
    logic [7:0] e [8];
    for (int i = 0; i < 8; i++) begin
      s1 += i + 1; s2 += s1; s3 += s2;
      e[i] = 8'(s3);
    end
    set_order_a(2'd3);
    for (int t = 0; t < 30; t++) begin
      ready_i_a = !(t >= 4 && t < 9);
      valid_i_a = (idx < 8);
      ch_i_a    = 2'd0;
      data_i_a  = 8'(idx + 1);
      @(negedge clk);
      if (t >= 4 && t < 9) begin
        n_cmp++;
        if (ready_o_a !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_ready_o[t=%0d]: got %0b expected 0", t, ready_o_a);
        end
        n_cmp++;
        if (valid_o_a !== 1'b1 || data_o_a !== e[1]) begin
          n_bad++;
          $display("FAIL bp_hold[t=%0d]: got v=%0b d=%0d expected v=1 d=%0d", t, valid_o_a, data_o_a, e[1]);
        end
      end
      if (valid_o_a && ready_i_a) begin
        got_ch.push_back(ch_o_a); got_d.push_back(data_o_a); got_cyc.push_back(cyc);
      end
      if (valid_i_a && ready_o_a) idx++;
      @(posedge clk); #1;
    end
    valid_i_a = 1'b0; ready_i_a = 1'b1;
    n_cmp++;
    if (got_d.size() != 8) begin
      n_bad++;
      $display("FAIL bp_count: got %0d expected 8", got_d.size());
    end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== e[i]) begin
        n_bad++;
        $display("FAIL bp_out[%0d]: got %0d expected %0d", i, got_d[i], e[i]);
      end
    end
  endtask

  task automatic test_clear();
    set_order_a(2'd1);
    drive_a(1'b1, 2'd0, 8'd5);
    drive_a(1'b1, 2'd0, 8'd5);
    clr_a = 1'b1; valid_i_a = 1'b1; ch_i_a = 2'd0; data_i_a = 8'd7;
    @(negedge clk);
    n_cmp++;
    if (ready_o_a !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_ready_o: got %0b expected 0", ready_o_a);
    end
    if (valid_o_a && ready_i_a) begin
      got_ch.push_back(ch_o_a); got_d.push_back(data_o_a); got_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    clr_a = 1'b0;
    idle_a(6);
    n_cmp++;
    if (got_d.size() != 0) begin
      n_bad++;
      $display("FAIL clear_inflight: got %0d outputs expected 0", got_d.size());
    end
    flush_a();
    drive_a(1'b1, 2'd0, 8'd1);
    idle_a(5);
    n_cmp++;
    if (got_d.size() != 1 || got_d[0] !== 8'd1) begin
      n_bad++;
      $display("FAIL clear_restart: got n=%0d d=%0d expected n=1 d=1", got_d.size(), (got_d.size() > 0) ? got_d[0] : 8'd0);
    end
  endtask

  task automatic test_oor_and_reset();
    set_order_a(2'd1);
    drive_a(1'b1, 2'd3, 8'd9);
    idle_a(5);
    n_cmp++;
    if (got_d.size() != 0) begin
      n_bad++;
      $display("FAIL oor_output: got %0d outputs expected 0", got_d.size());
    end
    drive_a(1'b1, 2'd0, 8'd5);
    idle_a(4);
    n_cmp++;
    if (got_d.size() != 1 || got_d[0] !== 8'd5 || got_ch[0] !== 2'd0) begin
      n_bad++;
      $display("FAIL oor_followup: got n=%0d d=%0d expected n=1 d=5", got_d.size(), (got_d.size() > 0) ? got_d[0] : 8'd0);
    end
    flush_a();
    drive_a(1'b1, 2'd0, 8'd5);
    drive_a(1'b1, 2'd0, 8'd5);
    rst_a = 1'b1; valid_i_a = 1'b1; data_i_a = 8'd5;
    @(negedge clk);
    n_cmp++;
    if (ready_o_a !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ready_o: got %0b expected 0", ready_o_a);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (valid_o_a !== 1'b0 || data_o_a !== 8'd0 || ch_o_a !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_outputs: got v=%0b d=%0d ch=%0d expected 0 0 0", valid_o_a, data_o_a, ch_o_a);
    end
    @(posedge clk); #1;
    rst_a = 1'b0; valid_i_a = 1'b0;
    flush_a();
    drive_a(1'b1, 2'd0, 8'd1);
    idle_a(5);
    n_cmp++;
    if (got_d.size() != 1 || got_d[0] !== 8'd1) begin
      n_bad++;
      $display("FAIL rst_restart: got n=%0d d=%0d expected n=1 d=1", got_d.size(), (got_d.size() > 0) ? got_d[0] : 8'd0);
    end
  endtask

  task automatic test_random();
    prev_stall = 1'b0; prev_d = '0; prev_ch = '0;
    for (int seg = 0; seg < 5; seg++) begin
      order_b = 3'($urandom_range(0, 7));
      clr_b = 1'b1; valid_i_b = 1'b0; ready_i_b = 1'b1;
      @(posedge clk); #1;
      clr_b = 1'b0;
      prev_stall = 1'b0;
      model_clear_b();
      exp_d.delete(); exp_ch.delete();
      for (int t = 0; t < 200; t++) begin
        valid_i_b = ($urandom_range(0, 3) != 0);
        ch_i_b    = 2'($urandom_range(0, 3));
        data_i_b  = 8'($urandom);
        ready_i_b = ($urandom_range(0, 3) != 0);
        cycle_b();
      end
      valid_i_b = 1'b0; ready_i_b = 1'b1;
      repeat (B_ST + 3) cycle_b();
      n_cmp++;
      if (exp_d.size() != 0) begin
        n_bad++;
        $display("FAIL rand_drain[seg %0d]: got %0d missing outputs expected 0", seg, exp_d.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_wrap();
    test_interleave();
    test_backpressure();
    test_clear();
    test_oor_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
